// File: rtl/alu_seq_pkg.sv
// Shared op-code constants and FSM state encoding for the alu_seq block.
package alu_seq_pkg;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOR  = 5'h06;
    localparam logic [4:0] OP_SLT  = 5'h07;
    localparam logic [4:0] OP_SLTU = 5'h08;
    localparam logic [4:0] OP_SLL  = 5'h09;
    localparam logic [4:0] OP_SRL  = 5'h0A;
    localparam logic [4:0] OP_SRA  = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h0C;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one partial product per cycle; low WIDTH bits kept.
// Only built when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH);
            r_acc   <= '0;
            r_mcand <= i_a;
            r_mplr  <= i_b;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                if (r_mplr[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_cnt   <= r_cnt - CW'(1);
            end else begin
                // Result consumed by the parent on this edge.
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done   = r_busy && (r_cnt == '0);
    assign o_result = r_acc;

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops, optional iterative MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise MUL reports err.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_err;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_res;

    assign w_sum    = alu_a + alu_b;
    assign w_diff   = alu_a - alu_b;
    assign w_shamt  = alu_b[SHW-1:0];
    assign w_accept = in_valid && (r_state == ST_IDLE);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (alu_op)
            OP_NOP:  w_res = '0;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (w_sum[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (w_diff[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_AND:  w_res = alu_a & alu_b;
            OP_OR:   w_res = alu_a | alu_b;
            OP_XOR:  w_res = alu_a ^ alu_b;
            OP_NOR:  w_res = ~(alu_a | alu_b);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            OP_SLL:  w_res = alu_a << w_shamt;
            OP_SRL:  w_res = alu_a >> w_shamt;
            OP_SRA:  w_res = $signed(alu_a) >>> w_shamt;
            default: w_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign w_is_mul = (alu_op == OP_MUL);

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && w_is_mul),
        .i_a     (alu_a),
        .i_b     (alu_b),
        .o_done  (w_mul_done),
        .o_result(w_mul_res)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_out   <= w_res;
                            r_zero  <= (w_res == '0);
                            r_ovf   <= w_ovf;
                            r_err   <= w_err;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                        r_out   <= w_mul_res;
                        r_zero  <= (w_mul_res == '0);
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign alu_out   = r_out;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal values 8..64).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from alu_b[SHW-1:0].
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  request carries a valid operation.
REQ-006 Port in_ready  output  1  block accepts a request this cycle.
REQ-007 Port alu_a  input  WIDTH  operand A, treated as signed unless the op states otherwise.
REQ-008 Port alu_b  input  WIDTH  operand B, treated as signed unless the op states otherwise.
REQ-009 Port alu_op  input  5  operation code.
REQ-010 Port out_valid  output  1  result registers hold a valid result.
REQ-011 Port out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port alu_out  output  WIDTH  registered result.
REQ-013 Port zero  output  1  registered, alu_out equals 0.
REQ-014 Port ovf  output  1  registered, signed overflow of ADD/SUB; 0 for every other op.
REQ-015 Port err  output  1  registered, op code unsupported or compiled out.

Function
REQ-016 Op codes: NOP 0x00 (0), ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, XOR 0x05, NOR 0x06, SLT 0x07 (signed), SLTU 0x08, SLL 0x09, SRL 0x0A, SRA 0x0B, MUL 0x0C (low WIDTH bits of product).
REQ-017 FSM states: IDLE, BUSY, DONE.
REQ-018 in_ready is 1 only in IDLE; a request is accepted when in_valid && in_ready.
REQ-019 For every non-MUL op, the transition is IDLE->DONE on acceptance, with alu_out/zero/ovf/err loaded on the same edge (latency 1 cycle).
REQ-020 For MUL, the transition is IDLE->BUSY; the shift-add iteration takes exactly WIDTH cycles in BUSY, then moves BUSY->DONE with the result loaded (latency WIDTH+1 cycles).
REQ-021 out_valid is 1 exactly in DONE; on out_valid && out_ready, the transition is DONE->IDLE.
REQ-022 While out_valid && !out_ready, alu_out, zero, ovf and err hold stable.
REQ-023 Operands and op are captured on acceptance; later input changes do not affect an in-flight op.
REQ-024 ADD/SUB wrap modulo 2^WIDTH; ovf=1 iff operand signs make the true signed result unrepresentable.
REQ-025 SLT/SLTU produce 1 or 0 in bit 0 with upper bits 0.
REQ-026 Shifts use alu_b[SHW-1:0] only; SRA replicates alu_a[WIDTH-1].
REQ-027 Op codes 0x0D..0x1F produce alu_out=0, zero=1, err=1, latency 1.
REQ-028 In_valid asserted outside IDLE is ignored with no effect.

Reset
REQ-029 rst_n low forces state IDLE, alu_out=0, zero=0, ovf=0, err=0, out_valid=0, and clears multiplier state, including mid-MUL or in DONE.
REQ-030 in_ready is 1 from the first rising edge after rst_n deasserts.

Configuration
REQ-031 With ALU_SEQ_MUL_EN defined, MUL behaves per REQ-020.
REQ-032 Without ALU_SEQ_MUL_EN, no multiplier logic exists and MUL is handled as an unsupported op per REQ-027.

Structure
REQ-033 Package alu_seq_pkg holds the op-code constants and the FSM state typedef.
REQ-034 Sub-module alu_seq_mul, instantiated only under ALU_SEQ_MUL_EN, is the iterative multiplier with start/done handshake.

Verification
REQ-035 WIDTH=32, ADD 0x7FFFFFFF+1 -> after 1 cycle alu_out=0x80000000, ovf=1, zero=0.
REQ-036 SUB 5-5 with out_ready held low for 3 cycles -> alu_out=0 and zero=1 held stable; in_ready=0 until the cycle after the out_ready handshake.
REQ-037 SRA 0x80000000 by alu_b=0x24 (amount 4) -> 0xF8000000; SLTU 0xFFFFFFFF,1 -> 0; SLT -> 1.
REQ-038 MUL 0xFFFF x 0x10001 with the macro defined -> out_valid exactly 33 cycles after acceptance, alu_out=0xFFFFFFFF; without the macro -> err=1, alu_out=0 after 1 cycle.
REQ-039 rst_n pulsed low mid-MUL (cycle 10) -> out_valid=0 and all outputs 0 immediately; next ADD 2+3 -> 5 after 1 cycle.
REQ-040 Op 0x1F -> err=1, zero=1; then ADD 1+1 -> err=0, alu_out=2.
